// File: rtl/complete_alu.sv
// Board-level ALU front end: switch-loaded A/B/opcode holding registers feeding a combinational ALU.
// Optional zero/carry flag outputs are built when COMPLETE_ALU_FLAGS_EN is defined.
module complete_alu #(
    parameter int BITS_DATA = 8,
    parameter int BITS_OP   = 6,
    parameter int BUTTONS   = 3
) (
    input  logic                 clk,
    input  logic                 i_reset,
    input  logic [BITS_DATA-1:0] i_switches,
    input  logic [BUTTONS-1:0]   i_buttons,
    output logic [BITS_DATA-1:0] o_result
`ifdef COMPLETE_ALU_FLAGS_EN
    ,
    output logic                 o_zero,
    output logic                 o_carry
`endif
);

    typedef enum logic [5:0] {
        OP_SRL = 6'b000010,
        OP_SRA = 6'b000011,
        OP_ADD = 6'b100000,
        OP_SUB = 6'b100010,
        OP_AND = 6'b100100,
        OP_OR  = 6'b100101,
        OP_XOR = 6'b100110,
        OP_NOR = 6'b100111
    } opcode_e;

    logic [BITS_DATA-1:0] a_q, a_d;
    logic [BITS_DATA-1:0] b_q, b_d;
    logic [BITS_OP-1:0]   op_q, op_d;
    logic [5:0]           op6;
    logic [BITS_DATA-1:0] result;

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= '0;
        end else begin
            a_q  <= a_d;
            b_q  <= b_d;
            op_q <= op_d;
        end
    end

    // Buttons are level strobes: a held button reloads on every edge.
    always_comb begin
        a_d  = a_q;
        b_d  = b_q;
        op_d = op_q;
        if (i_buttons[0]) a_d  = i_switches;
        if (i_buttons[1]) b_d  = i_switches;
        if (i_buttons[2]) op_d = i_switches[BITS_OP-1:0];
    end

    assign op6 = 6'(op_q);

    always_comb begin
        result = '0;
        case (op6)
            OP_ADD:  result = a_q + b_q;
            OP_SUB:  result = a_q - b_q;
            OP_AND:  result = a_q & b_q;
            OP_OR:   result = a_q | b_q;
            OP_XOR:  result = a_q ^ b_q;
            OP_NOR:  result = ~(a_q | b_q);
            // Full unsigned b as shift amount; oversized shifts give sign fill / zero.
            OP_SRA:  result = $signed(a_q) >>> b_q;
            OP_SRL:  result = a_q >> b_q;
            default: result = '0;
        endcase
    end

    assign o_result = result;

`ifdef COMPLETE_ALU_FLAGS_EN
    // a + b carries out exactly when a exceeds the ones' complement of b.
    assign o_zero  = (result == '0);
    assign o_carry = (op6 == OP_ADD) ? (a_q > ~b_q) :
                     (op6 == OP_SUB) ? (a_q < b_q)  : 1'b0;
`endif

endmodule

// File: tb/tb_complete_alu.sv
// Scoreboard bench for complete_alu: stimulus pushes model expectations, a monitor pops and compares.
// Checks the optional flags when COMPLETE_ALU_FLAGS_EN is defined.
module tb_complete_alu;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         i_reset = 1'b0;
    logic [W-1:0] i_switches = '0;
    logic [2:0]   i_buttons = '0;
    logic [W-1:0] o_result;
`ifdef COMPLETE_ALU_FLAGS_EN
    logic         o_zero;
    logic         o_carry;
`endif

    complete_alu #(.BITS_DATA(8), .BITS_OP(6), .BUTTONS(3)) dut (
        .clk        (clk),
        .i_reset    (i_reset),
        .i_switches (i_switches),
        .i_buttons  (i_buttons),
        .o_result   (o_result)
`ifdef COMPLETE_ALU_FLAGS_EN
        ,
        .o_zero     (o_zero),
        .o_carry    (o_carry)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int    res;
        bit    zero;
        bit    carry;
        string name;
    } exp_t;

    exp_t exp_q[$];
    event sample_req;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state, plain integers.
    int ma = 0, mb = 0, mop = 0;

    function automatic int model_result(int a, int b, int op);
        int s;
        case (op)
            32: return (a + b) % 256;
            34: return (a - b + 256) % 256;
            36: return a & b;
            37: return a | b;
            38: return a ^ b;
            39: return 255 - (a | b);
            3: begin
                s = (a >= 128) ? a - 256 : a;
                for (int k = 0; k < b && k < 16; k++)
                    s = (s < 0 && (s % 2) != 0) ? (s - 1) / 2 : s / 2;
                return (s + 256) % 256;
            end
            2: return (b >= 8) ? 0 : a / (1 << b);
            default: return 0;
        endcase
    endfunction

    function automatic bit model_carry(int a, int b, int op);
        if (op == 32) return (a + b) > 255;
        if (op == 34) return a < b;
        return 1'b0;
    endfunction

    task automatic push_expect(input string name);
        exp_t e;
        e.res   = model_result(ma, mb, mop);
        e.zero  = (e.res == 0);
        e.carry = model_carry(ma, mb, mop);
        e.name  = name;
        exp_q.push_back(e);
        -> sample_req;
    endtask

    task automatic do_cycle(input logic [7:0] sw, input logic [2:0] btn, input string name);
        @(negedge clk);
        i_switches = sw;
        i_buttons  = btn;
        @(posedge clk);
        if (btn[0]) ma  = int'(sw);
        if (btn[1]) mb  = int'(sw);
        if (btn[2]) mop = int'(sw[5:0]);
        #1;
        i_buttons = '0;
        push_expect(name);
    endtask

    task automatic async_reset(input string name);
        @(negedge clk);
        #2;
        i_reset = 1'b1;
        ma = 0; mb = 0; mop = 0;
        #1;
        push_expect(name);
        #1;
        i_reset = 1'b0;
    endtask

    // Monitor: pops one expectation per sample request and compares.
    initial begin
        exp_t e;
        forever begin
            @(sample_req);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard_empty: sample requested with no expectation");
            end else begin
                e = exp_q.pop_front();
                n_cmp++;
                if (int'(o_result) != e.res) begin
                    n_bad++;
                    $display("FAIL %s: result got 0x%02h expected 0x%02h", e.name, o_result, e.res[7:0]);
                end
`ifdef COMPLETE_ALU_FLAGS_EN
                n_cmp++;
                if (o_zero != e.zero || o_carry != e.carry) begin
                    n_bad++;
                    $display("FAIL %s_flags: zero/carry got %0b/%0b expected %0b/%0b",
                             e.name, o_zero, o_carry, e.zero, e.carry);
                end
`endif
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [7:0] ADD = 8'h20, SUB = 8'h22, AND_ = 8'h24, OR_ = 8'h25,
                           XOR_ = 8'h26, NOR_ = 8'h27, SRA = 8'h03, SRL = 8'h02;

    initial begin
        logic [7:0] ops [8];
        logic [7:0] sw;
        logic [2:0] btn;
        ops = '{ADD, SUB, AND_, OR_, XOR_, NOR_, SRA, SRL};

        #3;
        i_reset = 1'b1;
        #1;
        push_expect("reset_no_edge");
        #1;
        i_reset = 1'b0;

        do_cycle(8'h05, 3'b001, "load_a");
        do_cycle(8'h03, 3'b010, "load_b");
        do_cycle(ADD,   3'b100, "add_5_3");
        do_cycle(SUB,   3'b100, "sub_5_3");
        do_cycle(8'h03, 3'b001, "sub_load_a3");
        do_cycle(8'h05, 3'b010, "sub_3_5");

        do_cycle(8'h80, 3'b001, "sh_load_a");
        do_cycle(8'h02, 3'b010, "sh_load_b2");
        do_cycle(SRA,   3'b100, "sra_80_2");
        do_cycle(SRL,   3'b100, "srl_80_2");
        do_cycle(8'h09, 3'b010, "srl_80_9");
        do_cycle(SRA,   3'b100, "sra_80_9");
        do_cycle(8'hFF, 3'b010, "sra_80_ff");

        do_cycle(8'h0F, 3'b001, "lg_load_a");
        do_cycle(8'hF0, 3'b010, "lg_load_b");
        do_cycle(AND_,  3'b100, "and_0f_f0");
        do_cycle(OR_,   3'b100, "or_0f_f0");
        do_cycle(XOR_,  3'b100, "xor_0f_f0");
        do_cycle(NOR_,  3'b100, "nor_0f_f0");
        do_cycle(8'h3F, 3'b100, "undef_op_3f");

        do_cycle(8'h7A, 3'b011, "load_ab_7a");
        do_cycle(ADD,   3'b100, "add_7a_7a");
        do_cycle(8'hFF, 3'b011, "load_ab_ff");
        async_reset("reset_mid");
        do_cycle(8'h11, 3'b000, "idle_after_reset");
        do_cycle(8'hE0, 3'b111, "load_all_e0");

        for (int i = 0; i < 400; i++) begin
            sw  = 8'($urandom);
            btn = 3'($urandom);
            if (btn[2] && ($urandom_range(0, 9) < 8)) sw = ops[$urandom_range(0, 7)];
            if (btn[1] && ($urandom_range(0, 3) == 0)) sw = 8'($urandom_range(0, 12));
            do_cycle(sw, btn, "random");
            if ($urandom_range(0, 63) == 0) async_reset("random_reset");
        end

        #2;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
